// File: rtl/pkg_bram_if.sv
// ============================================================================
//  pkg_bram_if
//  Shared widths, types and the external-load sequencer state encoding.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package pkg_bram_if;

   localparam int WIDTH_EXT_ADDR   = 32;
   localparam int WIDTH_EXT_DATA   = 32;
   localparam int WIDTH_EXT_LENGTH = 16;
   localparam int WIDTH_BYTE       = 8;
   localparam int LENGTH_BUFF_LD   = 16;

   typedef logic [WIDTH_EXT_ADDR-1:0]   ext_addr_t;
   typedef logic [WIDTH_EXT_DATA-1:0]   ext_io_t;
   typedef logic [WIDTH_EXT_LENGTH-1:0] ext_len_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } fsm_ext_ld;

endpackage

`default_nettype wire

// File: rtl/ext_ld_fifo.sv
// ============================================================================
//  ext_ld_fifo
//  DEPTH-entry synchronous FIFO with occupancy count; DEPTH a power of two.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module ext_ld_fifo #(
   parameter int DEPTH          = 16,
   parameter int WIDTH_EXT_DATA = 32
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         push,
   input  logic [WIDTH_EXT_DATA-1:0]    push_data,
   input  logic                         pop,
   output logic [WIDTH_EXT_DATA-1:0]    pop_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH):0]       count
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_cnt_w = c_ptr_w + 1;

   logic [WIDTH_EXT_DATA-1:0] r_mem [DEPTH];
   logic [c_ptr_w-1:0]        r_wr_ptr;
   logic [c_ptr_w-1:0]        r_rd_ptr;
   logic [c_cnt_w-1:0]        r_count;
   logic                      w_push;
   logic                      w_pop;

   assign empty    = (r_count == '0);
   assign full     = (r_count == c_cnt_w'(DEPTH));
   assign count    = r_count;
   assign pop_data = r_mem[r_rd_ptr];

   // At full, a concurrent pop frees the head slot that the push then reuses.
   assign w_pop  = pop & ~empty;
   assign w_push = push & (~full | w_pop);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr] <= push_data;
   end

endmodule

`default_nettype wire

// File: rtl/ext_ld_seq.sv
// ============================================================================
//  ext_ld_seq
//  Issues a burst of external word reads and streams the returns through a
//  flow-controlled load buffer. Optional strided addressing: EXT_LD_STRIDE_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module ext_ld_seq
   import pkg_bram_if::*;
#(
   parameter int DEPTH          = LENGTH_BUFF_LD,
   parameter int BYTES_PER_WORD = WIDTH_EXT_DATA / WIDTH_BYTE
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        I_Start,
   input  logic [WIDTH_EXT_ADDR-1:0]   I_Base,
   input  logic [WIDTH_EXT_LENGTH-1:0] I_Length,
`ifdef EXT_LD_STRIDE_EN
   input  logic [WIDTH_EXT_ADDR-1:0]   I_Stride,
`endif
   output logic                        O_Busy,
   output logic                        O_Done,
   output logic                        O_Ext_Req,
   output logic [WIDTH_EXT_ADDR-1:0]   O_Ext_Addr,
   input  logic                        I_Ext_Gnt,
   input  logic                        I_Ext_RValid,
   input  logic [WIDTH_EXT_DATA-1:0]   I_Ext_RData,
   output logic                        O_Valid,
   output logic [WIDTH_EXT_DATA-1:0]   O_Data,
   input  logic                        I_Ready,
   output logic                        O_Ovf
);

   localparam int c_cnt_w = $clog2(DEPTH) + 1;

   fsm_ext_ld          r_state;
   ext_len_t           r_length;
   ext_len_t           r_issued;
   ext_len_t           r_returned;
   ext_len_t           r_popped;
   logic [c_cnt_w-1:0] r_outstanding;
   ext_addr_t          r_addr;
   logic               r_req;
   logic               r_busy;
   logic               r_done;
   logic               r_ovf;
`ifdef EXT_LD_STRIDE_EN
   ext_addr_t          r_stride;
`endif

   logic               w_grant;
   logic               w_ret;
   logic               w_pop;
   logic               w_push;
   logic               w_drop;
   logic               w_full;
   logic               w_empty;
   logic [c_cnt_w-1:0] w_count;
   logic [c_cnt_w-1:0] w_out_nxt;
   logic [c_cnt_w-1:0] w_occ_nxt;
   logic [c_cnt_w:0]   w_sum_nxt;
   logic               w_room;
   ext_len_t           w_issued_nxt;
   ext_len_t           w_popped_nxt;
   ext_addr_t          w_inc;
   ext_io_t            w_head;

`ifdef EXT_LD_STRIDE_EN
   assign w_inc = ext_addr_t'(r_stride * ext_addr_t'(BYTES_PER_WORD));
`else
   assign w_inc = ext_addr_t'(BYTES_PER_WORD);
`endif

   // Returns outside a transfer (e.g. after a reset abort) never touch the buffer.
   assign w_grant = r_req & I_Ext_Gnt;
   assign w_ret   = I_Ext_RValid & (r_state != IDLE) & (r_returned != r_length);
   assign w_pop   = ~w_empty & I_Ready;
   assign w_push  = w_ret & (~w_full | w_pop);
   assign w_drop  = w_ret & w_full & ~w_pop;

   assign w_issued_nxt = r_issued + WIDTH_EXT_LENGTH'(w_grant);
   assign w_popped_nxt = r_popped + WIDTH_EXT_LENGTH'(w_pop);
   assign w_out_nxt    = r_outstanding + c_cnt_w'(w_grant) - c_cnt_w'(w_ret);
   assign w_occ_nxt    = w_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
   assign w_sum_nxt    = {1'b0, w_out_nxt} + {1'b0, w_occ_nxt};
   assign w_room       = (w_sum_nxt < (c_cnt_w + 1)'(DEPTH));

   // The request is registered, so it is computed from next-cycle counts.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_length      <= '0;
         r_issued      <= '0;
         r_returned    <= '0;
         r_popped      <= '0;
         r_outstanding <= '0;
         r_addr        <= '0;
         r_req         <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_ovf         <= 1'b0;
`ifdef EXT_LD_STRIDE_EN
         r_stride      <= '0;
`endif
      end else begin
         r_done        <= 1'b0;
         r_issued      <= w_issued_nxt;
         r_returned    <= r_returned + WIDTH_EXT_LENGTH'(w_ret);
         r_popped      <= w_popped_nxt;
         r_outstanding <= w_out_nxt;
         if (w_drop)  r_ovf  <= 1'b1;
         if (w_grant) r_addr <= r_addr + w_inc;

         unique case (r_state)
            IDLE: begin
               if (I_Start) begin
                  if (I_Length != '0) begin
                     r_state       <= ISSUE;
                     r_busy        <= 1'b1;
                     r_length      <= I_Length;
                     r_addr        <= I_Base;
                     r_issued      <= '0;
                     r_returned    <= '0;
                     r_popped      <= '0;
                     r_outstanding <= '0;
                     r_req         <= (w_occ_nxt < c_cnt_w'(DEPTH));
`ifdef EXT_LD_STRIDE_EN
                     r_stride      <= I_Stride;
`endif
                  end else begin
                     r_done <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (w_issued_nxt == r_length) begin
                  r_state <= DRAIN;
                  r_req   <= 1'b0;
               end else begin
                  r_req   <= w_room;
               end
            end
            DRAIN: begin
               if (w_popped_nxt == r_length) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

   ext_ld_fifo #(
      .DEPTH          (DEPTH),
      .WIDTH_EXT_DATA (WIDTH_EXT_DATA)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (w_push),
      .push_data (I_Ext_RData),
      .pop       (w_pop),
      .pop_data  (w_head),
      .full      (w_full),
      .empty     (w_empty),
      .count     (w_count)
   );

   assign O_Busy     = r_busy;
   assign O_Done     = r_done;
   assign O_Ext_Req  = r_req;
   assign O_Ext_Addr = r_addr;
   assign O_Valid    = ~w_empty;
   assign O_Data     = w_head;
   assign O_Ovf      = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_ext_ld_seq.sv
// ============================================================================
//  tb_ext_ld_seq
//  Directed bench for ext_ld_seq with a fixed-latency external read responder.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ext_ld_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        I_Start = 1'b0;
   logic [31:0] I_Base = '0;
   logic [15:0] I_Length = '0;
   logic [31:0] I_Stride = 32'd1;
   logic        O_Busy, O_Done, O_Ext_Req, O_Valid, O_Ovf;
   logic [31:0] O_Ext_Addr, O_Data;
   logic        I_Ext_Gnt = 1'b0;
   logic        I_Ext_RValid = 1'b0;
   logic [31:0] I_Ext_RData = '0;
   logic        I_Ready = 1'b0;

   ext_ld_seq dut (
      .clock        (clk),
      .reset        (rst),
      .I_Start      (I_Start),
      .I_Base       (I_Base),
      .I_Length     (I_Length),
`ifdef EXT_LD_STRIDE_EN
      .I_Stride     (I_Stride),
`endif
      .O_Busy       (O_Busy),
      .O_Done       (O_Done),
      .O_Ext_Req    (O_Ext_Req),
      .O_Ext_Addr   (O_Ext_Addr),
      .I_Ext_Gnt    (I_Ext_Gnt),
      .I_Ext_RValid (I_Ext_RValid),
      .I_Ext_RData  (I_Ext_RData),
      .O_Valid      (O_Valid),
      .O_Data       (O_Data),
      .I_Ready      (I_Ready),
      .O_Ovf        (O_Ovf)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          rmode = 0;     // 0: ready high, 1: alternate, 2: ready low
   int          gmode = 0;     // 0: grant high, 1: alternate
   int          n_grants = 0;
   int          n_pops = 0;
   int          n_done = 0;
   int          last_pop_cyc = 0;
   int          done_cyc = 0;
   logic [31:0] exp_inc = 32'd4;
   logic [31:0] addr_q[$];
   logic [31:0] data_q[$];
   logic        pv0 = 1'b0, pv1 = 1'b0;
   logic [31:0] pa0 = '0, pa1 = '0;

   function automatic logic [31:0] rdata(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Responder/monitor: drives handshake inputs 1 ns after the falling edge,
   // returns each granted read two cycles after its grant.
   always @(negedge clk) begin
      #1;
      cyc++;
      I_Ext_Gnt    = (gmode == 0) ? 1'b1 : cyc[0];
      I_Ready      = (rmode == 0) ? 1'b1 : (rmode == 1) ? cyc[0] : 1'b0;
      I_Ext_RValid = pv1;
      I_Ext_RData  = pv1 ? rdata(pa1) : 32'hDEAD_BEEF;
      pv1 = pv0;
      pa1 = pa0;
      pv0 = 1'b0;
      if (O_Ext_Req && I_Ext_Gnt) begin
         addr_q.push_back(O_Ext_Addr);
         n_grants++;
         pv0 = 1'b1;
         pa0 = O_Ext_Addr;
      end
      if (O_Valid && I_Ready) begin
         data_q.push_back(O_Data);
         n_pops++;
         last_pop_cyc = cyc;
      end
      if (O_Done) begin
         n_done++;
         done_cyc = cyc;
      end
   end

   task automatic clear_mon();
      addr_q.delete();
      data_q.delete();
      n_grants = 0;
      n_pops   = 0;
      n_done   = 0;
   endtask

   task automatic pulse_start(input logic [31:0] base, input logic [15:0] len);
      @(negedge clk);
      I_Base   = base;
      I_Length = len;
      I_Start  = 1'b1;
      @(negedge clk);
      I_Start  = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int t;
      for (t = 0; t < 3000; t++) begin
         @(negedge clk);
         #2;
         if (n_done > 0) break;
      end
      chk({name, "_done_seen"}, 32'(n_done > 0), 32'd1);
   endtask

   task automatic check_stream(input string name, input logic [31:0] base,
                               input logic [15:0] len, input logic [31:0] exp_last);
      int bad_a = 0;
      int bad_d = 0;
      chk({name, "_grants"}, n_grants, 32'(len));
      chk({name, "_pops"},   n_pops,   32'(len));
      if (addr_q.size() > 0) chk({name, "_first_addr"}, addr_q[0], base);
      if (addr_q.size() >= int'(len)) chk({name, "_last_addr"}, addr_q[len-1], exp_last);
      for (int i = 0; i < addr_q.size(); i++)
         if (addr_q[i] !== base + 32'(i) * exp_inc) bad_a++;
      for (int i = 0; i < data_q.size(); i++)
         if (data_q[i] !== rdata(base + 32'(i) * exp_inc)) bad_d++;
      chk({name, "_addr_seq_bad"}, bad_a, 32'd0);
      chk({name, "_data_seq_bad"}, bad_d, 32'd0);
      chk({name, "_done_lat"}, done_cyc, last_pop_cyc + 1);
      chk({name, "_busy_at_done"}, O_Busy, 1'b0);
      chk({name, "_ovf"}, O_Ovf, 1'b0);
      @(negedge clk);
      #2;
      chk({name, "_done_pulse"}, n_done, 32'd1);
   endtask

   typedef struct {
      string       name;
      logic [31:0] base;
      logic [15:0] len;
      int          rm;
      int          gm;
      logic [31:0] last;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{"basic4",  32'h0000_1000, 16'd4,  0, 0, 32'h0000_100C};
      vecs[1] = '{"wrap2",   32'hFFFF_FFFC, 16'd2,  0, 0, 32'h0000_0000};
      vecs[2] = '{"single",  32'h0000_0080, 16'd1,  0, 0, 32'h0000_0080};
      vecs[3] = '{"toggle16",32'h0000_0200, 16'd16, 1, 1, 32'h0000_023C};
      vecs[4] = '{"len17",   32'h0000_4000, 16'd17, 1, 0, 32'h0000_4040};

      // Reset state
      repeat (3) @(negedge clk);
      #2;
      chk("rst_busy", O_Busy, 1'b0);
      chk("rst_done", O_Done, 1'b0);
      chk("rst_req",  O_Ext_Req, 1'b0);
      chk("rst_valid", O_Valid, 1'b0);
      chk("rst_ovf",  O_Ovf, 1'b0);
      chk("rst_addr", O_Ext_Addr, 32'h0);
      rst = 1'b0;

      // Zero length: done next cycle, no request, never busy
      clear_mon();
      @(negedge clk);
      I_Base = 32'h0000_5000; I_Length = 16'd0; I_Start = 1'b1;
      @(negedge clk);
      I_Start = 1'b0;
      #2;
      chk("len0_done", O_Done, 1'b1);
      chk("len0_busy", O_Busy, 1'b0);
      @(negedge clk);
      #2;
      chk("len0_done_drop", O_Done, 1'b0);
      repeat (4) @(negedge clk);
      #2;
      chk("len0_grants", n_grants, 32'd0);
      chk("len0_busy_later", O_Busy, 1'b0);

      // Table-driven transfers
      foreach (vecs[k]) begin
         clear_mon();
         rmode = vecs[k].rm;
         gmode = vecs[k].gm;
         pulse_start(vecs[k].base, vecs[k].len);
         wait_done(vecs[k].name);
         check_stream(vecs[k].name, vecs[k].base, vecs[k].len, vecs[k].last);
      end
      rmode = 0;
      gmode = 0;

      // Back-pressure: 16 grants then stall; a start mid-transfer is ignored
      clear_mon();
      rmode = 2;
      pulse_start(32'h0000_8000, 16'd20);
      repeat (40) @(negedge clk);
      #2;
      chk("bp_grants_stalled", n_grants, 32'd16);
      chk("bp_req_low", O_Ext_Req, 1'b0);
      chk("bp_valid", O_Valid, 1'b1);
      chk("bp_busy", O_Busy, 1'b1);
      pulse_start(32'h0000_9000, 16'd3);
      rmode = 0;
      wait_done("bp");
      check_stream("bp", 32'h0000_8000, 16'd20, 32'h0000_804C);

      // Reset after 3 of 8 grants; in-flight returns land in IDLE
      begin
         int t;
         int vseen;
         clear_mon();
         rmode = 2;
         pulse_start(32'h0000_3000, 16'd8);
         for (t = 0; t < 50; t++) begin
            @(negedge clk);
            #2;
            if (n_grants >= 3) break;
         end
         chk("abort_reach3", n_grants, 32'd3);
         @(posedge clk);
         #1;
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         rmode = 0;
         vseen = 0;
         for (t = 0; t < 6; t++) begin
            @(negedge clk);
            #2;
            if (O_Valid) vseen++;
         end
         chk("abort_valid_seen", vseen, 32'd0);
         chk("abort_pops", n_pops, 32'd0);
         chk("abort_grants", n_grants, 32'd3);
         chk("abort_busy", O_Busy, 1'b0);
         chk("abort_done", O_Done, 1'b0);
         chk("abort_req", O_Ext_Req, 1'b0);
         chk("abort_addr", O_Ext_Addr, 32'h0);
         chk("abort_ovf", O_Ovf, 1'b0);
      end

`ifdef EXT_LD_STRIDE_EN
      clear_mon();
      I_Stride = 32'd3;
      exp_inc  = 32'd12;
      pulse_start(32'h0, 16'd3);
      wait_done("stride3");
      check_stream("stride3", 32'h0, 16'd3, 32'h0000_0018);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
